// File: rtl/usb_ep_pingpong_buf.sv
// Multi-endpoint ping-pong packet store, app fills one bank while engine drains the other.
// Optional drop counter output: define USB_BUF_DROP_CNT_EN.
module usb_ep_pingpong_buf #(
  parameter int NUM_EP = 4,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  localparam int EP_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  localparam int LW = ADDR_W + 1
) (
  input  logic              phy_ulpi_clk,
  input  logic              reset_n,
  input  logic [EP_W-1:0]   app_ep,
  input  logic [ADDR_W-1:0] buf_in_addr,
  input  logic [DATA_W-1:0] buf_in_data,
  input  logic              buf_in_wren,
  input  logic              buf_in_commit,
  input  logic [LW-1:0]     buf_in_commit_len,
  output logic              buf_in_commit_ack,
  output logic [NUM_EP-1:0] buf_in_ready,
  input  logic [EP_W-1:0]   eng_ep,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic [DATA_W-1:0] eng_q,
  output logic [LW-1:0]     eng_len,
  output logic [NUM_EP-1:0] eng_hasdata,
  input  logic              eng_done,
  input  logic              eng_retry
`ifdef USB_BUF_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int RA_W = EP_W + 1 + ADDR_W;
  localparam int DEPTH = 2 ** RA_W;
  localparam logic [LW-1:0] MAXLEN = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        r_full [NUM_EP];
  logic [NUM_EP-1:0] r_fptr;
  logic [NUM_EP-1:0] r_dptr;
  logic [LW-1:0]     r_len0 [NUM_EP];
  logic [LW-1:0]     r_len1 [NUM_EP];
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic              r_ack;

  logic [NUM_EP-1:0] w_ready;
  logic [NUM_EP-1:0] w_has;
  logic              w_app_ok;
  logic              w_eng_ok;
  logic              w_wr_hit;
  logic              w_cm_hit;
  logic              w_dn_hit;
  logic [LW-1:0]     w_clen;
  logic [RA_W-1:0]   w_waddr;
  logic [RA_W-1:0]   w_raddr;

  assign w_app_ok = int'(app_ep) < NUM_EP;
  assign w_eng_ok = int'(eng_ep) < NUM_EP;

  // Per-channel status: fill bank free, drain bank holding a packet
  always_comb begin
    w_ready = '0;
    w_has   = '0;
    for (int e = 0; e < NUM_EP; e++) begin
      w_ready[e] = ~r_full[e][r_fptr[e]];
      w_has[e]   = r_full[e][r_dptr[e]];
    end
  end

  assign w_wr_hit = buf_in_wren & w_app_ok & w_ready[app_ep];
  assign w_cm_hit = buf_in_commit & w_app_ok & w_ready[app_ep];
  // done overrides retry; retry alone leaves the drain bank for re-reading
  assign w_dn_hit = eng_done & (eng_done | ~eng_retry)
                  & w_eng_ok & w_has[eng_ep];
  assign w_clen   = (buf_in_commit_len > MAXLEN) ? MAXLEN
                                                 : buf_in_commit_len;
  assign w_waddr  = {app_ep, r_fptr[app_ep], buf_in_addr};
  assign w_raddr  = {eng_ep, r_dptr[eng_ep], eng_addr};

  // Length of the current drain bank of the selected engine channel
  always_comb begin
    eng_len = '0;
    if (w_eng_ok)
      eng_len = r_dptr[eng_ep] ? r_len1[eng_ep] : r_len0[eng_ep];
  end

  // Bank ownership, pointers and stored lengths per channel
  always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fptr <= '0;
      r_dptr <= '0;
      r_ack  <= 1'b0;
      for (int e = 0; e < NUM_EP; e++) begin
        r_full[e] <= 2'b00;
        r_len0[e] <= '0;
        r_len1[e] <= '0;
      end
    end else begin
      r_ack <= w_cm_hit;
      for (int e = 0; e < NUM_EP; e++) begin
        if (w_cm_hit && int'(app_ep) == e) begin
          r_full[e][r_fptr[e]] <= 1'b1;
          r_fptr[e] <= ~r_fptr[e];
          if (r_fptr[e]) r_len1[e] <= w_clen;
          else           r_len0[e] <= w_clen;
        end
        if (w_dn_hit && int'(eng_ep) == e) begin
          r_full[e][r_dptr[e]] <= 1'b0;
          r_dptr[e] <= ~r_dptr[e];
        end
      end
    end
  end

  // Packet RAM write port, app side into its fill bank
  always_ff @(posedge phy_ulpi_clk) begin
    if (w_wr_hit) r_mem[w_waddr] <= buf_in_data;
  end

  // Registered engine read, one cycle after address
  always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
    if (!reset_n) r_q <= '0;
    else          r_q <= r_mem[w_raddr];
  end

`ifdef USB_BUF_DROP_CNT_EN
  logic        w_wr_drop;
  logic        w_cm_drop;
  logic [16:0] w_cnt_sum;
  logic [15:0] r_drop;

  assign w_wr_drop = buf_in_wren & ~w_wr_hit;
  assign w_cm_drop = buf_in_commit & ~w_cm_hit;
  assign w_cnt_sum = {1'b0, r_drop} + 17'(w_wr_drop) + 17'(w_cm_drop);

  // Saturating count of rejected commits and dropped writes
  always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
    if (!reset_n)          r_drop <= '0;
    else if (w_cnt_sum[16]) r_drop <= 16'hFFFF;
    else                   r_drop <= w_cnt_sum[15:0];
  end

  assign drop_cnt = r_drop;
`endif

  assign buf_in_ready      = w_ready;
  assign eng_hasdata       = w_has;
  assign eng_q             = r_q;
  assign buf_in_commit_ack = r_ack;

endmodule

// File: doc/usb_ep_pingpong_buf.md
# usb_ep_pingpong_buf

Multi-endpoint, double-buffered packet store between the application and the USB device protocol engine, running in the ULPI clock domain. It generalises the single-buffer IN path (addr/data/wren/commit/commit_len/commit_ack) to NUM_EP channels, each with two banks of 2^ADDR_W bytes. The application fills one bank while the engine drains the other. Each channel tracks its own bank ownership, lengths and ready/hasdata status.

## Interface
Parameters:
- NUM_EP, 4, number of endpoint channels (1..16); EP_W = max(1, clog2(NUM_EP))
- ADDR_W, 9, byte address width per bank; bank size 2^ADDR_W
- DATA_W, 8, data width

Ports:
- phy_ulpi_clk  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- app_ep  in  EP_W  channel select for all app-side strobes
- buf_in_addr  in  ADDR_W  write byte address within fill bank
- buf_in_data  in  DATA_W  write data
- buf_in_wren  in  1  write strobe
- buf_in_commit  in  1  commit fill bank of app_ep (1-cycle pulse)
- buf_in_commit_len  in  ADDR_W+1  packet length in bytes
- buf_in_commit_ack  out  1  commit accepted pulse
- buf_in_ready  out  NUM_EP  per-channel fill bank free
- eng_ep  in  EP_W  channel select for engine side
- eng_addr  in  ADDR_W  read address within drain bank
- eng_q  out  DATA_W  read data, 1-cycle latency
- eng_len  out  ADDR_W+1  length of drain bank of eng_ep
- eng_hasdata  out  NUM_EP  per-channel drain bank full
- eng_done  in  1  packet ACKed by host; release drain bank of eng_ep
- eng_retry  in  1  packet not ACKed; keep drain bank for retransmit

## Operation
- Storage: one RAM of NUM_EP*2*2^ADDR_W words, index {ep, bank, addr}.
- Per channel: full[1:0], fill_ptr, drain_ptr, len0, len1 (ADDR_W+1 bits each).
- buf_in_ready[e] = ~full[fill_ptr[e]]; eng_hasdata[e] = full[drain_ptr[e]].
- Write: wren with buf_in_ready[app_ep]=1 writes {app_ep, fill_ptr, addr}; with ready=0 the write is dropped.
- Commit with ready=1: len[fill_ptr] <= min(commit_len, 2^ADDR_W); full[fill_ptr] <= 1; fill_ptr toggles; ack pulses.
- Commit with ready=0: ignored, no ack, counted as drop (see Configuration).
- Length 0 is legal (zero-length packet): hasdata asserts and eng_len=0.
- eng_done with hasdata[eng_ep]=1: full[drain_ptr] <= 0; drain_ptr toggles. With hasdata=0: ignored.
- eng_retry: no state change; the same bank is re-read. eng_done and eng_retry together: eng_done wins.
- Same channel, commit and done in one cycle: both apply. Commit targets fill_ptr and done targets drain_ptr, which are distinct banks when both are legal.
- Different channels are fully independent.

## Timing
- Reset values: all full=0, all pointers=0, all lengths=0; buf_in_ready all 1; eng_hasdata all 0; buf_in_commit_ack=0; eng_q=0; eng_len=0.
- Reset mid-packet discards all banks immediately (asynchronous assertion). Deassertion is synchronous to phy_ulpi_clk.
- Commit at edge N: buf_in_commit_ack=1 for cycle N+1 only; eng_hasdata and buf_in_ready update in N+1.
- eng_q is valid the cycle after eng_addr/eng_ep are sampled. Registered RAM read, no read-enable.
- eng_len is combinational from registered state (mux by eng_ep).
- After eng_done at edge N: buf_in_ready recovers in N+1. Re-commit is allowed from N+1.
- Back-to-back commits on the same channel fill both banks in consecutive cycles. A third commit is rejected.

## Configuration
- USB_BUF_DROP_CNT_EN defined: adds output drop_cnt [15:0]. It increments on every rejected commit and on every dropped write strobe, saturates at 16'hFFFF, and resets to 0.
- Not defined: the port and counter are absent. Rejected commits and writes are silently ignored.

## Test plan
- Reset, then commit len 64 on ep1 -> ack pulse at N+1; eng_hasdata=4'b0010; buf_in_ready stays 4'b1111 (second bank free).
- Two commits on ep0 (lengths 10, 20) -> buf_in_ready[0]=0; eng_len=10 then 20 after one eng_done; third commit has no ack; drop_cnt=1 when USB_BUF_DROP_CNT_EN is defined.
- Write bytes 0xA0..0xAF to ep2, commit 16, read addr 0..15 -> eng_q returns 0xA0..0xAF one cycle after each address; eng_retry then a re-read returns the same data.
- commit_len=600 with ADDR_W=9 -> eng_len=512; commit_len=0 -> hasdata=1, eng_len=0.
- Same-cycle commit on ep3 (bank 1) and eng_done on ep3 (bank 0) -> bank 0 freed, bank 1 full, hasdata[3]=1, ready[3]=1.
- Assert reset_n low with all channels full -> ready=all 1 and hasdata=0 without a clock edge.
